int_to_float: RTL and testbench

Converts a 32-bit two's-complement signed integer to an IEEE-754 single-precision value. It sits directly upstream of the single-precision adder, so integer operands can be fed into the floating-point datapath. It uses the same stb/ack stream handshake on input and output, so its output connects straight to an adder operand port. It is a multi-cycle FSM with one-bit-per-cycle normalisation, matching the adder's area and latency trade-off.

---
 rtl/int_to_float.sv | 157 +++++++++++++++
 tb/tb_int_to_float.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// ============================================================================
// Module   : int_to_float
// Purpose  : 32-bit signed integer to IEEE-754 single converter, stb/ack
//            streaming, one-bit-per-cycle normalisation. Define
//            INT_TO_FLOAT_TRUNC_EN to truncate instead of round-to-nearest-even.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    S_GET_A     = 3'd0,
    S_CONVERT_0 = 3'd1,
    S_CONVERT_1 = 3'd2,
    S_CONVERT_2 = 3'd3,
    S_ROUND     = 3'd4,
    S_PACK      = 3'd5,
    S_PUT_Z     = 3'd6
  } state_t;

  state_t             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_v;
  logic [31:0]        r_z;
  logic [31:0]        r_output_z;
  logic               r_z_s;
  logic signed [7:0]  r_z_e;
  logic [23:0]        r_z_m;
  logic               r_input_a_ack;
  logic               r_output_z_stb;

  logic [31:0]        w_a_mag;
  logic [7:0]         w_exp_biased;
  logic               w_round_up;

`ifdef INT_TO_FLOAT_TRUNC_EN
  assign w_round_up = 1'b0;
`else
  logic               r_guard;
  logic               r_round_bit;
  logic               r_sticky;

  assign w_round_up = r_guard & (r_round_bit | r_sticky | r_z_m[0]);
`endif

  // Negating 0x80000000 wraps back to 0x80000000, which is its true magnitude.
  assign w_a_mag      = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_exp_biased = r_z_e[7:0] + 8'd127;

  assign input_a_ack  = r_input_a_ack;
  assign output_z     = r_output_z;
  assign output_z_stb = r_output_z_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_GET_A;
      r_a            <= 32'd0;
      r_v            <= 32'd0;
      r_z            <= 32'd0;
      r_output_z     <= 32'd0;
      r_z_s          <= 1'b0;
      r_z_e          <= 8'sd0;
      r_z_m          <= 24'd0;
      r_input_a_ack  <= 1'b0;
      r_output_z_stb <= 1'b0;
`ifndef INT_TO_FLOAT_TRUNC_EN
      r_guard        <= 1'b0;
      r_round_bit    <= 1'b0;
      r_sticky       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_GET_A: begin
          r_input_a_ack <= 1'b1;
          if (r_input_a_ack && input_a_stb) begin
            r_a           <= input_a;
            r_input_a_ack <= 1'b0;
            r_state       <= S_CONVERT_0;
          end
        end

        S_CONVERT_0: begin
          if (r_a == 32'd0) begin
            r_z     <= 32'd0;
            r_state <= S_PUT_Z;
          end else begin
            r_z_s   <= r_a[31];
            r_v     <= w_a_mag;
            r_z_e   <= 8'sd31;
            r_state <= S_CONVERT_1;
          end
        end

        S_CONVERT_1: begin
          if (!r_v[31]) begin
            r_v   <= r_v << 1;
            r_z_e <= r_z_e - 8'sd1;
          end else begin
            r_state <= S_CONVERT_2;
          end
        end

        S_CONVERT_2: begin
          r_z_m       <= r_v[31:8];
`ifndef INT_TO_FLOAT_TRUNC_EN
          r_guard     <= r_v[7];
          r_round_bit <= r_v[6];
          r_sticky    <= |r_v[5:0];
`endif
          r_state     <= S_ROUND;
        end

        S_ROUND: begin
          // A carry out of the mantissa wraps it to zero and bumps the exponent.
          if (w_round_up) begin
            r_z_m <= r_z_m + 24'd1;
            if (&r_z_m) begin
              r_z_e <= r_z_e + 8'sd1;
            end
          end
          r_state <= S_PACK;
        end

        S_PACK: begin
          r_z     <= {r_z_s, w_exp_biased, r_z_m[22:0]};
          r_state <= S_PUT_Z;
        end

        S_PUT_Z: begin
          r_output_z_stb <= 1'b1;
          r_output_z     <= r_z;
          if (r_output_z_stb && output_z_ack) begin
            r_output_z_stb <= 1'b0;
            r_state        <= S_GET_A;
          end
        end

        default: begin
          r_state <= S_GET_A;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_int_to_float.sv
// ============================================================================
// Module   : tb_int_to_float
// Purpose  : Self-checking bench for int_to_float with an arithmetic reference
//            model, stream scoreboard and directed vectors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_to_float;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int n_cmp;
  int n_err;
  int cyc;
  int cap_cyc;
  int n_out;
  logic prev_stb;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  int_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: locate the leading one, then round the discarded remainder
  // arithmetically against half an ulp.
  function automatic logic [31:0] model_z(input logic [31:0] a);
    logic        s;
    logic [31:0] mag;
    logic [63:0] m;
    logic [63:0] q;
    int          p;
    int          e;
    int          sh;
`ifndef INT_TO_FLOAT_TRUNC_EN
    logic [63:0] rem;
    logic [63:0] half;
`endif
    if (a == 32'd0) return 32'd0;
    s   = a[31];
    mag = s ? (32'd0 - a) : a;
    m   = {32'd0, mag};
    p   = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh = p - 23;
      q  = m >> sh;
`ifndef INT_TO_FLOAT_TRUNC_EN
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
`endif
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] a);
    logic [31:0] mag;
    int          p;
    if (a == 32'd0) return 2;
    mag = a[31] ? (32'd0 - a) : a;
    p   = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    return 6 + (31 - p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting, required a DUT response", name);
  endtask

  // Scoreboard bookkeeping on each edge (pre-edge DUT values are seen here).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      if (input_a_ack && input_a_stb) begin
        exp_q.push_back(model_z(input_a));
        lat_q.push_back(model_lat(input_a));
        cap_cyc = cyc;
      end
      if (output_z_stb && output_z_ack && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        n_out++;
      end
    end
  end

  always @(negedge rst) begin
    exp_q.delete();
    lat_q.delete();
  end

  // Compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (rst && output_z_stb) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_z: got stb with 0x%08h, required no output", output_z);
      end else begin
        check("model_z", output_z, exp_q[0]);
        check("ack_low_while_busy", 32'(input_a_ack), 32'd0);
        if (!prev_stb) check("model_latency", 32'(cyc - cap_cyc), 32'(lat_q[0]));
      end
    end
    prev_stb = rst && output_z_stb;
  end

  task automatic wait_capture(output bit got);
    got = 1'b0;
    for (int n = 0; n < 80 && !got; n++) begin
      @(posedge clk);
      if (input_a_ack && input_a_stb) got = 1'b1;
    end
  endtask

  task automatic convert(input logic [31:0] a, input logic [31:0] exp_z,
                         input int exp_lat, input int hold);
    bit got;
    @(negedge clk);
    input_a     = a;
    input_a_stb = 1'b1;
    wait_capture(got);
    @(negedge clk);
    input_a_stb = 1'b0;
    if (!got) begin
      fail_timeout("capture");
      return;
    end
    for (int n = 0; n < 60 && !output_z_stb; n++) @(negedge clk);
    if (!output_z_stb) begin
      fail_timeout("output_stb");
      return;
    end
    check("dir_z", output_z, exp_z);
    check("dir_latency", 32'(cyc - cap_cyc), 32'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_z", output_z, exp_z);
      check("hold_stb", 32'(output_z_stb), 32'd1);
      check("hold_ack", 32'(input_a_ack), 32'd0);
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    check("stb_drop", 32'(output_z_stb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          seen;
    int          n_out0;
    logic [31:0] vals[4];

    n_cmp = 0; n_err = 0; cyc = 0; cap_cyc = 0; n_out = 0; prev_stb = 1'b0;
    rst = 1'b0; input_a = 32'd0; input_a_stb = 1'b0; output_z_ack = 1'b0;

    // Pin the reference model to hand-computed values.
    check("pin_model_one",   model_z(32'd1),        32'h3F800000);
    check("pin_model_hundred", model_z(32'd100),    32'h42C80000);
    check("pin_model_minint", model_z(32'h80000000), 32'hCF000000);
    check("pin_model_lat_one", 32'(model_lat(32'd1)), 32'd37);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(input_a_ack), 32'd0);
    check("reset_stb", 32'(output_z_stb), 32'd0);
    check("reset_z",   output_z, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ack_after_release", 32'(input_a_ack), 32'd1);

    convert(32'd1,          32'h3F800000, 37, 0);
    convert(32'hFFFFFFFF,   32'hBF800000, 37, 0);
    convert(32'd0,          32'h00000000, 2,  0);
    convert(32'h80000000,   32'hCF000000, 6,  0);
    convert(32'hFFFFFFFE,   32'hC0000000, 36, 0);
`ifdef INT_TO_FLOAT_TRUNC_EN
    convert(32'd16777217,   32'h4B800000, 13, 0);
    convert(32'd16777219,   32'h4B800001, 13, 0);
    convert(32'h7FFFFFFF,   32'h4EFFFFFF, 7,  0);
`else
    convert(32'd16777217,   32'h4B800000, 13, 0);
    convert(32'd16777219,   32'h4B800002, 13, 0);
    convert(32'h7FFFFFFF,   32'h4F000000, 7,  0);
`endif
    convert(32'd100,        32'h42C80000, 31, 5);

    // Back-to-back with stb held high across transfers.
    vals[0] = 32'd5; vals[1] = 32'hFFFFFF9C; vals[2] = 32'h00FFFFFF; vals[3] = 32'h12345678;
    n_out0 = n_out;
    output_z_ack = 1'b1;
    @(negedge clk);
    input_a     = vals[0];
    input_a_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_capture(got);
      if (!got) fail_timeout("b2b_capture");
      @(negedge clk);
      if (i < 3) input_a = vals[i + 1];
      else       input_a_stb = 1'b0;
    end
    for (int n = 0; n < 80 && n_out != n_out0 + 4; n++) @(negedge clk);
    check("b2b_count", 32'(n_out - n_out0), 32'd4);
    output_z_ack = 1'b0;

    // Asynchronous reset while normalising a = 1.
    @(negedge clk);
    input_a     = 32'd1;
    input_a_stb = 1'b1;
    wait_capture(got);
    if (!got) fail_timeout("rst_capture");
    @(negedge clk);
    input_a_stb = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_ack", 32'(input_a_ack), 32'd0);
    check("async_rst_stb", 32'(output_z_stb), 32'd0);
    check("async_rst_z",   output_z, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (output_z_stb) seen = 1;
    end
    check("no_output_after_reset", 32'(seen), 32'd0);
    convert(32'd2, 32'h40000000, 36, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
